// File: rtl/data_cache_pkg.sv
// Shared definitions for the data cache: FSM encodings, load/store funct3 codes, block geometry.
package data_cache_pkg;

    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned BLOCK_BITS  = 8 * BLOCK_BYTES;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    // Byte lanes touched by a store; halfwords ignore addr[0], words ignore addr[1:0].
    function automatic logic [3:0] store_be(input logic [1:0] f3, input logic [1:0] off);
        case (f3)
            ST_SB:   return 4'b0001 << off;
            ST_SH:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/data_cache_load_data_aligner.sv
// Selects byte/halfword/word from a cached word and sign- or zero-extends it per load funct3.
module load_data_aligner
    import data_cache_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data_c
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        case (byte_off)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        sel_half = byte_off[1] ? word[31:16] : word[15:0];

        case (funct3)
            LD_LB:   load_data_c = {{24{sel_byte[7]}}, sel_byte};
            LD_LH:   load_data_c = {{16{sel_half[15]}}, sel_half};
            LD_LW:   load_data_c = word;
            LD_LBU:  load_data_c = {24'd0, sel_byte};
            LD_LHU:  load_data_c = {16'd0, sel_half};
            default: load_data_c = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate data cache in front of 128-bit block memory.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [3:0]            DATA_MEM_READ,
    input  logic [2:0]            DATA_MEM_WRITE,
    input  logic [31:0]           DATA_MEM_ADDR,
    input  logic [31:0]           DATA_MEM_WRITE_DATA,
    output logic [31:0]           DATA_MEM_READ_DATA,
    output logic                  DATA_MEM_BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [27:0]           MEM_ADDRESS,
    output logic [BLOCK_BITS-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_BITS-1:0] MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 28 - INDEX_BITS;

    logic [BLOCK_BITS-1:0] data_array [LINES];
    logic [TAG_BITS-1:0]   tag_array  [LINES];
    logic [LINES-1:0]      valid;
    logic [LINES-1:0]      dirty;

    state_t state, next_state;

    logic [TAG_BITS-1:0]   addr_tag;
    logic [INDEX_BITS-1:0] addr_index;
    logic [1:0]            word_sel;
    logic [1:0]            byte_off;
    logic                  is_store, is_load, request, hit;
    logic                  store_hit, alloc_done;
    logic [BLOCK_BITS-1:0] cur_line, merged_line;
    logic [31:0]           cur_word, store_bytes, aligned_data;
    logic [3:0]            be;

    assign addr_tag   = DATA_MEM_ADDR[31:4+INDEX_BITS];
    assign addr_index = DATA_MEM_ADDR[3+INDEX_BITS:4];
    assign word_sel   = DATA_MEM_ADDR[3:2];
    assign byte_off   = DATA_MEM_ADDR[1:0];

    // A simultaneous store suppresses the load.
    assign is_store = DATA_MEM_WRITE[2];
    assign is_load  = DATA_MEM_READ[3] & ~is_store;
    assign request  = is_load | is_store;
    assign hit      = valid[addr_index] & (tag_array[addr_index] == addr_tag);

    assign store_hit  = (state == IDLE) & is_store & hit;
    assign alloc_done = (state == ALLOCATE) & ~MEM_BUSYWAIT;

    assign cur_line = data_array[addr_index];
    assign cur_word = cur_line[32*int'(word_sel) +: 32];
    assign be       = store_be(DATA_MEM_WRITE[1:0], byte_off);

    // Replicate store data so every enabled lane sees the right bytes.
    always_comb begin
        case (DATA_MEM_WRITE[1:0])
            ST_SB:   store_bytes = {4{DATA_MEM_WRITE_DATA[7:0]}};
            ST_SH:   store_bytes = {2{DATA_MEM_WRITE_DATA[15:0]}};
            default: store_bytes = DATA_MEM_WRITE_DATA;
        endcase
        merged_line = cur_line;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged_line[32*int'(word_sel) + 8*b +: 8] = store_bytes[8*b +: 8];
            end
        end
    end

    load_data_aligner u_aligner (
        .word        (cur_word),
        .byte_off    (byte_off),
        .funct3      (DATA_MEM_READ[2:0]),
        .load_data_c (aligned_data)
    );

    assign DATA_MEM_READ_DATA = ((state == IDLE) && is_load && hit) ? aligned_data : 32'd0;

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (request && !hit) next_state = dirty[addr_index] ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: if (!MEM_BUSYWAIT) next_state = ALLOCATE;
            ALLOCATE:  if (!MEM_BUSYWAIT) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        MEM_READ          = 1'b0;
        MEM_WRITE         = 1'b0;
        MEM_ADDRESS       = 28'd0;
        MEM_WRITEDATA     = '0;
        DATA_MEM_BUSYWAIT = 1'b0;
        case (state)
            IDLE: DATA_MEM_BUSYWAIT = request & ~hit;
            WRITEBACK: begin
                DATA_MEM_BUSYWAIT = 1'b1;
                MEM_WRITE         = 1'b1;
                MEM_ADDRESS       = {tag_array[addr_index], addr_index};
                MEM_WRITEDATA     = cur_line;
            end
            ALLOCATE: begin
                DATA_MEM_BUSYWAIT = 1'b1;
                MEM_READ          = 1'b1;
                MEM_ADDRESS       = DATA_MEM_ADDR[31:4];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid <= '0;
            dirty <= '0;
        end else if (alloc_done) begin
            valid[addr_index] <= 1'b1;
            dirty[addr_index] <= 1'b0;
        end else if (store_hit) begin
            dirty[addr_index] <= 1'b1;
        end
    end

    // Data and tags are not cleared; a reset-time fill is dropped.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (alloc_done) begin
                data_array[addr_index] <= MEM_READDATA;
                tag_array[addr_index]  <= addr_tag;
            end else if (store_hit) begin
                data_array[addr_index] <= merged_line;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic        miss_seen;

    // A request that completes right after its own refill is not a hit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
            miss_seen  <= 1'b0;
        end else if (state == IDLE && request) begin
            if (!hit) begin
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
                miss_seen <= 1'b1;
            end else begin
                if (!miss_seen && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
                miss_seen <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache with a small latency-2 block memory model.
module tb_data_cache;
    import data_cache_pkg::*;

    logic         CLK;
    logic         RESET;
    logic [3:0]   DATA_MEM_READ;
    logic [2:0]   DATA_MEM_WRITE;
    logic [31:0]  DATA_MEM_ADDR;
    logic [31:0]  DATA_MEM_WRITE_DATA;
    logic [31:0]  DATA_MEM_READ_DATA;
    logic         DATA_MEM_BUSYWAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    int tests_run;
    int tests_failed;

    logic [127:0] mem [32];
    logic [1:0]   mcnt;

    data_cache #(.INDEX_BITS(3)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .DATA_MEM_READ       (DATA_MEM_READ),
        .DATA_MEM_WRITE      (DATA_MEM_WRITE),
        .DATA_MEM_ADDR       (DATA_MEM_ADDR),
        .DATA_MEM_WRITE_DATA (DATA_MEM_WRITE_DATA),
        .DATA_MEM_READ_DATA  (DATA_MEM_READ_DATA),
        .DATA_MEM_BUSYWAIT   (DATA_MEM_BUSYWAIT),
        .MEM_READ            (MEM_READ),
        .MEM_WRITE           (MEM_WRITE),
        .MEM_ADDRESS         (MEM_ADDRESS),
        .MEM_WRITEDATA       (MEM_WRITEDATA),
        .MEM_READDATA        (MEM_READDATA),
        .MEM_BUSYWAIT        (MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory stays busy two cycles per request, then completes on the third.
    always @(posedge CLK) begin
        if (RESET || !(MEM_READ || MEM_WRITE) || mcnt == 2'd2) mcnt <= 2'd0;
        else                                                   mcnt <= mcnt + 2'd1;
    end
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mcnt != 2'd2);
    assign MEM_READDATA = MEM_READ ? mem[MEM_ADDRESS[4:0]] : 128'd0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input logic [3:0] rd, input logic [2:0] wr,
                          input logic [31:0] addr, input logic [31:0] wd);
        @(negedge CLK);
        DATA_MEM_READ       = rd;
        DATA_MEM_WRITE      = wr;
        DATA_MEM_ADDR       = addr;
        DATA_MEM_WRITE_DATA = wd;
        #1;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20 && DATA_MEM_BUSYWAIT; i++) @(negedge CLK);
        #1;
        check(tag, 128'(DATA_MEM_BUSYWAIT), 128'(1'b0));
    endtask

    localparam logic [3:0] RD_NONE = 4'b0000;
    localparam logic [2:0] WR_NONE = 3'b000;
    localparam logic [3:0] RD_LB   = {1'b1, LD_LB};
    localparam logic [3:0] RD_LH   = {1'b1, LD_LH};
    localparam logic [3:0] RD_LW   = {1'b1, LD_LW};
    localparam logic [3:0] RD_LBU  = {1'b1, LD_LBU};
    localparam logic [3:0] RD_LHU  = {1'b1, LD_LHU};
    localparam logic [2:0] WR_SB   = {1'b1, ST_SB};
    localparam logic [2:0] WR_SH   = {1'b1, ST_SH};
    localparam logic [2:0] WR_SW   = {1'b1, ST_SW};

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 32; i++) mem[i] = 128'd0;
        mem[1] = {32'h0000_DDDD, 32'h0000_CCCC, 32'h0000_BBBB, 32'h0000_AAAA};
        mem[9] = {32'h9333_3333, 32'h9222_2222, 32'h9111_1111, 32'h1234_5678};
        mem[2] = {32'h0, 32'h0, 32'h0000_00F0, 32'h2000_A520};

        RESET = 1'b1;
        DATA_MEM_READ = RD_NONE; DATA_MEM_WRITE = WR_NONE;
        DATA_MEM_ADDR = 32'd0;   DATA_MEM_WRITE_DATA = 32'd0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("rst_mem_read",  128'(MEM_READ), 128'(1'b0));
        check("rst_mem_write", 128'(MEM_WRITE), 128'(1'b0));
        check("rst_mem_addr",  128'(MEM_ADDRESS), 128'(28'd0));
        check("rst_mem_wdata", MEM_WRITEDATA, 128'd0);
        check("rst_busy",      128'(DATA_MEM_BUSYWAIT), 128'(1'b0));
        check("rst_rdata",     128'(DATA_MEM_READ_DATA), 128'(32'd0));

        // Clean miss on block 1
        access(RD_LW, WR_NONE, 32'h10, 32'd0);
        check("miss_busy_idle", 128'(DATA_MEM_BUSYWAIT), 128'(1'b1));
        check("miss_no_rd_idle", 128'(MEM_READ), 128'(1'b0));
        @(negedge CLK); #1;
        check("alloc_busy",  128'(DATA_MEM_BUSYWAIT), 128'(1'b1));
        check("alloc_read",  128'(MEM_READ), 128'(1'b1));
        check("alloc_write", 128'(MEM_WRITE), 128'(1'b0));
        check("alloc_addr",  128'(MEM_ADDRESS), 128'(28'h000_0001));
        wait_ready("alloc_done");
        check("lw_10", 128'(DATA_MEM_READ_DATA), 128'(32'h0000_AAAA));

        // Store hits and sub-word loads
        access(RD_NONE, WR_SB, 32'h13, 32'hFFFF_FF80);
        check("sb_busy",    128'(DATA_MEM_BUSYWAIT), 128'(1'b0));
        check("sb_traffic", 128'(MEM_READ | MEM_WRITE), 128'(1'b0));
        access(RD_LB, WR_NONE, 32'h13, 32'd0);
        check("lb_13", 128'(DATA_MEM_READ_DATA), 128'(32'hFFFF_FF80));
        access(RD_LBU, WR_NONE, 32'h13, 32'd0);
        check("lbu_13", 128'(DATA_MEM_READ_DATA), 128'(32'h0000_0080));
        check("lbu_traffic", 128'(MEM_READ | MEM_WRITE | DATA_MEM_BUSYWAIT), 128'(1'b0));
        access(RD_NONE, WR_SW, 32'h14, 32'h8001_2345);
        access(RD_LH, WR_NONE, 32'h16, 32'd0);
        check("lh_16", 128'(DATA_MEM_READ_DATA), 128'(32'hFFFF_8001));
        access(RD_LHU, WR_NONE, 32'h17, 32'd0);
        check("lhu_17", 128'(DATA_MEM_READ_DATA), 128'(32'h0000_8001));
        access(RD_LH, WR_NONE, 32'h14, 32'd0);
        check("lh_14", 128'(DATA_MEM_READ_DATA), 128'(32'h0000_2345));
        access(RD_LW, WR_NONE, 32'h17, 32'd0);
        check("lw_17", 128'(DATA_MEM_READ_DATA), 128'(32'h8001_2345));
        access(RD_NONE, WR_SH, 32'h1B, 32'h1234_BEEF);
        access(RD_LW, WR_NONE, 32'h18, 32'd0);
        check("lw_18", 128'(DATA_MEM_READ_DATA), 128'(32'hBEEF_CCCC));

        // Store and load together: store wins
        access(RD_LW, WR_SB, 32'h1C, 32'h0000_0011);
        check("both_rdata", 128'(DATA_MEM_READ_DATA), 128'(32'd0));
        access(RD_LW, WR_NONE, 32'h1C, 32'd0);
        check("lw_1c", 128'(DATA_MEM_READ_DATA), 128'(32'h0000_DD11));
        access(RD_NONE, WR_NONE, 32'h0, 32'd0);
        check("idle_rdata", 128'(DATA_MEM_READ_DATA), 128'(32'd0));

        // Dirty miss: write back line 1 then fetch block 9
        access(RD_LW, WR_NONE, 32'h90, 32'd0);
        check("dmiss_busy", 128'(DATA_MEM_BUSYWAIT), 128'(1'b1));
        @(negedge CLK); #1;
        check("wb_write", 128'(MEM_WRITE), 128'(1'b1));
        check("wb_read",  128'(MEM_READ), 128'(1'b0));
        check("wb_addr",  128'(MEM_ADDRESS), 128'(28'h000_0001));
        check("wb_data",  MEM_WRITEDATA,
              {32'h0000_DD11, 32'hBEEF_CCCC, 32'h8001_2345, 32'h8000_AAAA});
        for (int i = 0; i < 20 && !MEM_READ; i++) @(negedge CLK);
        #1;
        check("wb2alloc_read",  128'(MEM_READ), 128'(1'b1));
        check("wb2alloc_write", 128'(MEM_WRITE), 128'(1'b0));
        check("wb2alloc_addr",  128'(MEM_ADDRESS), 128'(28'h000_0009));
        wait_ready("dmiss_done");
        check("lw_90", 128'(DATA_MEM_READ_DATA), 128'(32'h1234_5678));

        // Reset in the middle of an allocate
        access(RD_LW, WR_NONE, 32'h20, 32'd0);
        @(negedge CLK); #1;
        check("pre_rst_read", 128'(MEM_READ), 128'(1'b1));
        RESET = 1'b1;
        DATA_MEM_READ = RD_NONE;
        @(negedge CLK); #1;
        check("post_rst_read", 128'(MEM_READ), 128'(1'b0));
        check("post_rst_busy", 128'(DATA_MEM_BUSYWAIT), 128'(1'b0));
        RESET = 1'b0;
        access(RD_LW, WR_NONE, 32'h20, 32'd0);
        check("remiss_busy", 128'(DATA_MEM_BUSYWAIT), 128'(1'b1));
        wait_ready("remiss_done");
        check("lw_20", 128'(DATA_MEM_READ_DATA), 128'(32'h2000_A520));
        access(RD_LW, WR_NONE, 32'h24, 32'd0);
        check("lw_24", 128'(DATA_MEM_READ_DATA), 128'(32'h0000_00F0));
        access(RD_LW, WR_NONE, 32'h20, 32'd0);
        check("lw_20_hit", 128'(DATA_MEM_READ_DATA), 128'(32'h2000_A520));
        access(RD_LBU, WR_NONE, 32'h21, 32'd0);
        check("lbu_21", 128'(DATA_MEM_READ_DATA), 128'(32'h0000_00A5));
        access(RD_NONE, WR_NONE, 32'h0, 32'd0);
`ifdef DCACHE_STATS_EN
        check("stat_miss", 128'(dut.miss_count), 128'(32'd1));
        check("stat_hit",  128'(dut.hit_count),  128'(32'd3));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
